// File: rtl/byte_reg_arb_pkg.sv
// rtl/byte_reg_arb_pkg.sv - shared types and constants for the byte register arbiter
package byte_reg_arb_pkg;

   localparam int unsigned LANE_W = 8;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK0    = 2'd1,
      LOCK1    = 2'd2
   } arb_state_e;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_REQ0 = 2'd1;
   localparam logic [1:0] OWNER_REQ1 = 2'd2;

   function automatic logic [1:0] owner_of(input arb_state_e s);
      case (s)
         LOCK0:   return OWNER_REQ0;
         LOCK1:   return OWNER_REQ1;
         default: return OWNER_NONE;
      endcase
   endfunction

endpackage

// File: rtl/byte_reg_bank.sv
// rtl/byte_reg_bank.sv - byte-lane register with per-lane write enable and sync reset to zero
module byte_reg_bank
   import byte_reg_arb_pkg::*;
#(
   parameter int p_nbytes = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [p_nbytes-1:0]          wr_en,
   input  logic [LANE_W*p_nbytes-1:0]   wr_d,
   output logic [LANE_W*p_nbytes-1:0]   q
);

   logic [LANE_W*p_nbytes-1:0] q_q;
   logic [LANE_W*p_nbytes-1:0] q_d;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < p_nbytes; i++) begin
         if (wr_en[i]) begin
            q_d[i*LANE_W +: LANE_W] = wr_d[i*LANE_W +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/byte_reg_rr_arb.sv
// rtl/byte_reg_rr_arb.sv - two-requester round-robin arbiter with lock, owning a byte-writable register
module byte_reg_rr_arb
   import byte_reg_arb_pkg::*;
#(
   parameter int p_nbytes = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req0_val,
   output logic                         req0_rdy,
   input  logic [p_nbytes-1:0]          req0_en,
   input  logic [LANE_W*p_nbytes-1:0]   req0_d,
   input  logic                         req0_lock,
   input  logic                         req1_val,
   output logic                         req1_rdy,
   input  logic [p_nbytes-1:0]          req1_en,
   input  logic [LANE_W*p_nbytes-1:0]   req1_d,
   input  logic                         req1_lock,
   output logic [LANE_W*p_nbytes-1:0]   q,
   output logic [1:0]                   owner
);

   arb_state_e state_q, state_d;
   logic       ptr_q, ptr_d;   // 0 favours req0, 1 favours req1
   logic       rdy0, rdy1, tx0, tx1;
   logic [p_nbytes-1:0]        wr_en;
   logic [LANE_W*p_nbytes-1:0] wr_d;

   always_comb begin
      rdy0    = 1'b0;
      rdy1    = 1'b0;
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = '0;
      wr_d    = req0_d;

      if (!reset) begin
         case (state_q)
            UNLOCKED: begin
               rdy0 = req0_val & (~req1_val | ~ptr_q);
               rdy1 = req1_val & (~req0_val |  ptr_q);
            end
            LOCK0:   rdy0 = req0_val;
            LOCK1:   rdy1 = req1_val;
            default: state_d = UNLOCKED;
         endcase
      end

      tx0 = req0_val & rdy0;
      tx1 = req1_val & rdy1;

      // Every grant hands priority to the other side, so an unlock also favours the peer.
      if (tx0) begin
         wr_en   = req0_en;
         wr_d    = req0_d;
         ptr_d   = 1'b1;
         state_d = req0_lock ? LOCK0 : UNLOCKED;
      end else if (tx1) begin
         wr_en   = req1_en;
         wr_d    = req1_d;
         ptr_d   = 1'b0;
         state_d = req1_lock ? LOCK1 : UNLOCKED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= UNLOCKED;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   byte_reg_bank #(.p_nbytes(p_nbytes)) u_bank (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .wr_d  (wr_d),
      .q     (q)
   );

   assign req0_rdy = rdy0;
   assign req1_rdy = rdy1;
   assign owner    = owner_of(state_q);

endmodule
